// File: rtl/uart_pkg.sv
// Shared constants for the framed UART transmitter: parity modes, FSM encoding
// and the parity helper used when a word is loaded into the shifter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity over the low dbits of word; odd mode is the inverse of even.
  function automatic logic parity_bit(input logic [8:0] word, input int dbits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < dbits) p = p ^ word[i];
    end
    return p ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes while full are
// dropped even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: words queue in a small FIFO and are framed as
// start / data (LSB first) / optional parity / stop bits on a registered line.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a buffered word
//   ST_START  | start bit (low)
//   ST_DATA   | payload bits, LSB first
//   ST_PARITY | parity bit (only when parity is enabled)
//   ST_STOP   | stop bit(s), high
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_b,
  input  logic                          tx_send,
  input  logic [DATA_BITS-1:0]          data_in,
  output logic                          ready,
  output logic                          tx,
  output logic                          txing,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  import uart_pkg::*;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
      $error("PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 par_bit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_done;
  logic                 frame_done;
  logic                 pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (tx_send),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready      = !fifo_full;
  assign bit_done   = (bit_cnt == '0);
  assign frame_done = (state == ST_STOP) && bit_done && (bit_idx == STOP_LAST);
  // Popping at the end of the last stop bit gives back-to-back frames.
  assign pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      overflow <= 1'b0;
    end else if (tx_send && !ready) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      txing   <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      state   <= ST_START;
      tx      <= 1'b0;
      txing   <= 1'b1;
      bit_cnt <= CNT_LAST;
      bit_idx <= '0;
      shreg   <= fifo_rd_data;
      par_bit <= parity_bit(9'(fifo_rd_data), DATA_BITS, PARITY_MODE);
    end else if (state != ST_IDLE) begin
      if (!bit_done) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
      end else begin
        bit_cnt <= CNT_LAST;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_MODE != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          ST_PARITY: begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
          ST_STOP: begin
            if (bit_idx == STOP_LAST) begin
              state   <= ST_IDLE;
              tx      <= 1'b1;
              txing   <= 1'b0;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
            txing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: five configurations share one stimulus
// sequence; a negedge monitor compares each frame against a scoreboard word.
module tb_uart_tx_framed;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       tx_send;
  logic [8:0] din;
  int         sel;

  logic [4:0] send_v, ready_v, tx_v, txing_v, ovf_v;
  logic [2:0] cnt_v [5];

  always #5 clk = ~clk;

  assign send_v[0] = tx_send && (sel == 0);
  assign send_v[1] = tx_send && (sel == 1);
  assign send_v[2] = tx_send && (sel == 2);
  assign send_v[3] = tx_send && (sel == 3);
  assign send_v[4] = tx_send && (sel == 4);

  uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset_b(reset_b), .tx_send(send_v[0]), .data_in(din[7:0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .txing(txing_v[0]), .fifo_count(cnt_v[0]), .overflow(ovf_v[0]));
  uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset_b(reset_b), .tx_send(send_v[1]), .data_in(din[7:0]), .ready(ready_v[1]),
    .tx(tx_v[1]), .txing(txing_v[1]), .fifo_count(cnt_v[1]), .overflow(ovf_v[1]));
  uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset_b(reset_b), .tx_send(send_v[2]), .data_in(din[7:0]), .ready(ready_v[2]),
    .tx(tx_v[2]), .txing(txing_v[2]), .fifo_count(cnt_v[2]), .overflow(ovf_v[2]));
  uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
    .clk(clk), .reset_b(reset_b), .tx_send(send_v[3]), .data_in(din[7:0]), .ready(ready_v[3]),
    .tx(tx_v[3]), .txing(txing_v[3]), .fifo_count(cnt_v[3]), .overflow(ovf_v[3]));
  uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_5n1 (
    .clk(clk), .reset_b(reset_b), .tx_send(send_v[4]), .data_in(din[4:0]), .ready(ready_v[4]),
    .tx(tx_v[4]), .txing(txing_v[4]), .fifo_count(cnt_v[4]), .overflow(ovf_v[4]));

  logic       obs_tx, obs_txing, obs_ready, obs_ovf;
  logic [2:0] obs_count;
  assign obs_tx    = tx_v[sel];
  assign obs_txing = txing_v[sel];
  assign obs_ready = ready_v[sel];
  assign obs_ovf   = ovf_v[sel];
  assign obs_count = cnt_v[sel];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int cfg_cpb = 16, cfg_dbits = 8, cfg_pmode = 0, cfg_sbits = 1;
  int exp_q [$];
  bit mon_en = 1'b0;
  bit in_frame = 1'b0;
  int fcyc, flen, bad, cur_word;
  int frames_done = 0;
  int last_start = 0, last_end = -1000, last_gap = 0;
  int push_cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference waveform: slot 0 start, then payload LSB first, parity, stops.
  function automatic logic exp_bit(input int w, input int slot);
    int p;
    p = 0;
    if (slot == 0) return 1'b0;
    if (slot <= cfg_dbits) return 1'((w >> (slot - 1)) & 1);
    for (int i = 0; i < cfg_dbits; i++) p = p ^ ((w >> i) & 1);
    if (cfg_pmode != 0 && slot == cfg_dbits + 1) return 1'((cfg_pmode == 2) ? (p ^ 1) : p);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!mon_en || reset_b !== 1'b1) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && obs_tx === 1'b0) begin
        in_frame = 1'b1;
        fcyc = 0;
        bad = 0;
        flen = cfg_cpb * (1 + cfg_dbits + ((cfg_pmode != 0) ? 1 : 0) + cfg_sbits);
        last_gap = cycle - last_end - 1;
        last_start = cycle;
        if (exp_q.size() == 0) begin
          cur_word = -1;
          bad = 1;
        end else begin
          cur_word = exp_q.pop_front();
        end
      end
      if (in_frame) begin
        if (obs_tx !== exp_bit(cur_word, fcyc / cfg_cpb) || obs_txing !== 1'b1) bad++;
        fcyc++;
        if (fcyc == flen) begin
          checks++;
          assert (bad === 0) else begin
            errors++;
            $error("FAIL frame word=%0h: bad cycles observed=%0d expected=0", cur_word, bad);
          end
          in_frame = 1'b0;
          last_end = cycle;
          frames_done++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_cfg(input int s, input int cpb, input int dbits, input int pmode, input int sbits);
    sel = s; cfg_cpb = cpb; cfg_dbits = dbits; cfg_pmode = pmode; cfg_sbits = sbits;
    @(negedge clk);
  endtask

  task automatic push(input logic [8:0] w, input bit accept);
    tx_send = 1'b1;
    din = w;
    if (accept) exp_q.push_back(int'(w));
    @(negedge clk);
    push_cycle = cycle;
    tx_send = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk(tag, {obs_tx, obs_txing}, 32'b10);
  endtask

  initial begin
    int f0, idle_bad;
    tx_send = 1'b0;
    din = '0;
    sel = 0;
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", obs_tx, 32'd1);
    chk("rst_txing", obs_txing, 32'd0);
    chk("rst_count", obs_count, 32'd0);
    chk("rst_ready", obs_ready, 32'd1);
    chk("rst_overflow", obs_ovf, 32'd0);
    reset_b = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_frame_after_reset", obs_tx, 32'd1);

    // 8N1 single word, first-bit latency of one edge
    set_cfg(0, 16, 8, 0, 1);
    f0 = frames_done;
    push(9'h41, 1'b1);
    wait_frames(f0 + 1, 400);
    chk("latency_8n1", 32'(last_start - push_cycle), 32'd1);
    check_idle("idle_after_8n1");

    // Six writes into a depth-4 FIFO while idle: the sixth is dropped
    f0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      chk("ready_before_push", obs_ready, 32'(i < 5));
      push(9'(i), i < 5);
    end
    chk("overflow_set", obs_ovf, 32'd1);
    chk("count_full", obs_count, 32'd4);
    wait_frames(f0 + 5, 1200);
    chk("gap_back_to_back", 32'(last_gap), 32'd0);
    chk("count_drained", obs_count, 32'd0);
    chk("overflow_sticky", obs_ovf, 32'd1);
    check_idle("idle_after_burst");

    // Reset during data bit 3 with two words still queued
    push(9'h11, 1'b1);
    push(9'h22, 1'b1);
    push(9'h33, 1'b1);
    repeat (70) @(negedge clk);
    chk("pre_reset_count", obs_count, 32'd2);
    chk("pre_reset_bit3", obs_tx, 32'd0);
    mon_en = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    chk("abort_tx", obs_tx, 32'd1);
    chk("abort_txing", obs_txing, 32'd0);
    chk("abort_count", obs_count, 32'd0);
    chk("abort_ready", obs_ready, 32'd1);
    chk("abort_overflow", obs_ovf, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_b = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (obs_tx !== 1'b1 || obs_txing !== 1'b0) idle_bad++;
    end
    chk("silent_after_reset", 32'(idle_bad), 32'd0);
    mon_en = 1'b1;
    f0 = frames_done;
    push(9'h5A, 1'b1);
    wait_frames(f0 + 1, 400);
    chk("latency_after_reset", 32'(last_start - push_cycle), 32'd1);

    // 8E1 with 0x7F: parity bit 1, 176-cycle frame
    set_cfg(1, 16, 8, 1, 1);
    f0 = frames_done;
    push(9'h7F, 1'b1);
    wait_frames(f0 + 1, 400);
    check_idle("idle_after_8e1");

    // 8O1 with 0x01: parity bit 0
    set_cfg(2, 16, 8, 2, 1);
    f0 = frames_done;
    push(9'h01, 1'b1);
    wait_frames(f0 + 1, 400);
    check_idle("idle_after_8o1");

    // 8N2 back-to-back frames of 0x00 then 0x01
    set_cfg(3, 16, 8, 0, 2);
    f0 = frames_done;
    push(9'h00, 1'b1);
    push(9'h01, 1'b1);
    wait_frames(f0 + 2, 800);
    chk("gap_8n2", 32'(last_gap), 32'd0);
    check_idle("idle_after_8n2");

    // 5N1 at 4 clocks per bit with 0x15
    set_cfg(4, 4, 5, 0, 1);
    f0 = frames_done;
    push(9'h15, 1'b1);
    wait_frames(f0 + 1, 200);
    chk("latency_5n1", 32'(last_start - push_cycle), 32'd1);
    check_idle("idle_after_5n1");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; SHALL be at least 2.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame; SHALL be in the range 5..9.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd; value 3 SHALL be rejected at elaboration.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; SHALL be 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: input buffer entries; SHALL be a power of 2, at least 2.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset_b  in  1  asynchronous, active-low reset.
REQ-008 tx_send  in  1  write strobe; the word is accepted on a rising edge where tx_send=1 and ready=1.
REQ-009 data_in  in  DATA_BITS  word to transmit, sampled on the accepting edge.
REQ-010 ready  out  1  FIFO not full (combinational from the registered count).
REQ-011 tx  out  1  registered serial line; idles high.
REQ-012 txing  out  1  high while a frame (start through last stop bit) is on tx.
REQ-013 fifo_count  out  clog2(FIFO_DEPTH)+1  number of words buffered, excluding the word in flight.
REQ-014 overflow  out  1  sticky; set when tx_send=1 while ready=0; cleared only by reset.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-016 IDLE: if the FIFO is non-empty, the FSM pops the head word into a shift register on that edge, enters START and drives tx=0.
REQ-017 Each bit SHALL occupy exactly CLKS_PER_BIT cycles, timed by a bit counter that resets on every bit transition.
REQ-018 DATA SHALL shift out DATA_BITS bits LSB first, then go to PARITY or STOP.
REQ-019 Parity bit: even mode = XOR of the payload; odd mode = its inverse.
REQ-020 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, a non-empty FIFO SHALL pop and enter START on the same edge (no idle gap); otherwise the FSM returns to IDLE.
REQ-022 Latency: a word accepted on edge E into an empty FIFO while in IDLE SHALL drive tx low from edge E+1.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; a push while full SHALL be dropped even if a pop occurs on the same edge.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-025 txing SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-026 While reset_b=0: tx=1, txing=0, state=IDLE, fifo_count=0, ready=1, overflow=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and discard all buffered words.
REQ-028 The first frame after reset release SHALL start only after a new accepted write.

Structure
REQ-029 A shared package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state encoding.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH), instantiated once.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-031 8N1, write 0x41 -> tx = 0,1,0,0,0,0,0,1,0,1, each bit for 16 cycles; txing high for 160 cycles.
REQ-032 8E1, write 0x7F -> parity bit 1; frame is 176 cycles. 8O1, write 0x01 -> parity bit 0.
REQ-033 8N2, writes 0x00 then 0x01 on consecutive edges -> two frames of 176 cycles each, back-to-back, second start bit immediately after 32 high cycles.
REQ-034 FIFO_DEPTH=4, six consecutive writes 0x00..0x05 while idle -> 0x00..0x04 accepted, ready=0 after the fifth, 0x05 dropped, overflow=1; output order 0x00..0x04.
REQ-035 Assert reset_b=0 during the DATA bit 3 of a frame with 2 words queued -> tx=1 and fifo_count=0 immediately; no output after release until a new write.
REQ-036 DATA_BITS=5, CLKS_PER_BIT=4, 5N1, write 0x15 -> tx = 0,1,0,1,0,1,1, each bit for 4 cycles.
